// File: rtl/platform_collider_if.sv
// Handshake/bus bundle between the platform table, the collider and the doodle physics block.
// PLATFORM_COLLIDER_OVERRUN_EN adds the overrun and hit_count signals.
interface platform_collider_if #(
  parameter int N_PLAT = 93
);
  logic                             frame_tick;
  logic [10:0]                      doodle_x;
  logic [9:0]                       doodle_y;
  logic                             falling;
  logic signed [N_PLAT-1:0][1:0][10:0] platforms;
  logic [N_PLAT-1:0]                platform_activation;
  logic                             busy;
  logic                             done;
  logic                             hit;
  logic [6:0]                       hit_index;
  logic signed [10:0]               hit_y;
`ifdef PLATFORM_COLLIDER_OVERRUN_EN
  logic                             overrun;
  logic [6:0]                       hit_count;

  modport master (
    output frame_tick, doodle_x, doodle_y, falling, platforms, platform_activation,
    input  busy, done, hit, hit_index, hit_y, overrun, hit_count
  );
  modport slave (
    input  frame_tick, doodle_x, doodle_y, falling, platforms, platform_activation,
    output busy, done, hit, hit_index, hit_y, overrun, hit_count
  );
`else
  modport master (
    output frame_tick, doodle_x, doodle_y, falling, platforms, platform_activation,
    input  busy, done, hit, hit_index, hit_y
  );
  modport slave (
    input  frame_tick, doodle_x, doodle_y, falling, platforms, platform_activation,
    output busy, done, hit, hit_index, hit_y
  );
`endif
endinterface

// File: rtl/platform_collider.sv
// Sequential per-frame scan of the platform table for the first landing hit.
// Optional PLATFORM_COLLIDER_OVERRUN_EN: sticky overrun flag and per-scan hit_count.
module platform_collider #(
  parameter int N_PLAT   = 93,
  parameter int PLAT_W   = 100,
  parameter int DOODLE_W = 80,
  parameter int DOODLE_H = 80,
  parameter int LAND_TOL = 10
) (
  input logic clk,
  input logic rst,
  platform_collider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_next;
  logic   start;
  logic   last;
  logic   busy_w;

  logic [6:0]  idx;
  logic [10:0] sh_x;
  logic [9:0]  sh_y;
  logic        sh_fall;

  logic        work_hit;
  logic [6:0]  work_idx;
  logic [10:0] work_y;

  logic        hit_r;
  logic [6:0]  hit_index_r;
  logic [10:0] hit_y_r;

  logic [10:0] px_raw, py_raw;
  logic signed [12:0] dl, dr, feet, pl, pr, pt, pb;
  logic        match, take;
  logic        nx_hit;
  logic [6:0]  nx_idx;
  logic [10:0] nx_y;

  assign last   = (idx == 7'(N_PLAT - 1));
  assign busy_w = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: if (bus.frame_tick) begin
        state_next = SCAN;
        start      = 1'b1;
      end
      SCAN:    if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Doodle values zero-extend, platform values sign-extend, so off-screen platforms never wrap.
  assign px_raw = bus.platforms[idx][1];
  assign py_raw = bus.platforms[idx][0];
  assign dl     = $signed({2'b00, sh_x});
  assign dr     = dl + 13'(DOODLE_W - 1);
  assign feet   = $signed({3'b000, sh_y}) + 13'(DOODLE_H - 1);
  assign pl     = $signed({{2{px_raw[10]}}, px_raw});
  assign pr     = pl + 13'(PLAT_W - 1);
  assign pt     = $signed({{2{py_raw[10]}}, py_raw});
  assign pb     = pt + 13'(LAND_TOL - 1);

  assign match = bus.platform_activation[idx] & sh_fall &
                 (dr >= pl) & (dl <= pr) & (feet >= pt) & (feet <= pb);
  assign take   = match & ~work_hit;
  assign nx_hit = work_hit | match;
  assign nx_idx = take ? idx : work_idx;
  assign nx_y   = take ? py_raw : work_y;

`ifdef PLATFORM_COLLIDER_OVERRUN_EN
  logic       overrun_r;
  logic [6:0] work_cnt;
  logic [6:0] hit_count_r;
  logic [6:0] nx_cnt;

  assign nx_cnt = work_cnt + 7'(match);

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_r   <= 1'b0;
      work_cnt    <= '0;
      hit_count_r <= '0;
    end else begin
      overrun_r <= overrun_r | (bus.frame_tick & busy_w);
      if (start) work_cnt <= '0;
      else if (state == SCAN) begin
        work_cnt <= nx_cnt;
        if (last) hit_count_r <= nx_cnt;
      end
    end
  end

  assign bus.overrun   = overrun_r;
  assign bus.hit_count = hit_count_r;
`endif

  // The final slot is folded in on the way into DONE so results are valid in the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      sh_x        <= '0;
      sh_y        <= '0;
      sh_fall     <= 1'b0;
      work_hit    <= 1'b0;
      work_idx    <= '0;
      work_y      <= '0;
      hit_r       <= 1'b0;
      hit_index_r <= '0;
      hit_y_r     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sh_x     <= bus.doodle_x;
          sh_y     <= bus.doodle_y;
          sh_fall  <= bus.falling;
          work_hit <= 1'b0;
          work_idx <= '0;
          work_y   <= '0;
          idx      <= '0;
        end
        SCAN: begin
          idx      <= idx + 7'd1;
          work_hit <= nx_hit;
          work_idx <= nx_idx;
          work_y   <= nx_y;
          if (last) begin
            hit_r       <= nx_hit;
            hit_index_r <= nx_idx;
            hit_y_r     <= nx_y;
          end
        end
        DONE:    idx <= '0;
        default: idx <= '0;
      endcase
    end
  end

  assign bus.busy      = busy_w;
  assign bus.done      = (state == DONE);
  assign bus.hit       = hit_r;
  assign bus.hit_index = hit_index_r;
  assign bus.hit_y     = $signed(hit_y_r);

endmodule

// File: tb/tb_platform_collider.sv
// Self-checking bench for platform_collider; honours PLATFORM_COLLIDER_OVERRUN_EN when defined.
module tb_platform_collider;
  localparam int N   = 93;
  localparam int PW  = 100;
  localparam int DW  = 80;
  localparam int DH  = 80;
  localparam int TOL = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  platform_collider_if #(.N_PLAT(N)) bus ();

  platform_collider #(
    .N_PLAT(N), .PLAT_W(PW), .DOODLE_W(DW), .DOODLE_H(DH), .LAND_TOL(TOL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: walk every slot with plain integer arithmetic.
  function automatic void ref_scan(input int dx, input int dy, input bit fall,
                                   output int h, output int ix, output int y, output int cnt);
    h = 0; ix = 0; y = 0; cnt = 0;
    for (int i = 0; i < N; i++) begin
      logic signed [10:0] a, b;
      int px, py, feet;
      a = bus.platforms[i][1];
      b = bus.platforms[i][0];
      px = a; py = b; feet = dy + DH - 1;
      if (bus.platform_activation[i] && fall && dx + DW - 1 >= px && dx <= px + PW - 1 &&
          feet >= py && feet <= py + TOL - 1) begin
        cnt++;
        if (h == 0) begin h = 1; ix = i; y = py; end
      end
    end
  endfunction

  // phase: 0 idle, 1..N scanning, N+1 done cycle
  int m_phase = 0;
  int p_hit, p_idx, p_y, p_cnt;
  int o_hit = 0, o_idx = 0, o_y = 0, o_cnt = 0;
  bit o_ovr = 1'b0;

  always @(posedge clk) begin : model
    int h, ix, y, c;
    if (rst) begin
      m_phase <= 0;
      o_hit <= 0; o_idx <= 0; o_y <= 0; o_cnt <= 0; o_ovr <= 1'b0;
    end else if (m_phase == 0) begin
      if (bus.frame_tick) begin
        ref_scan(int'(bus.doodle_x), int'(bus.doodle_y), bus.falling, h, ix, y, c);
        p_hit <= h; p_idx <= ix; p_y <= y; p_cnt <= c;
        m_phase <= 1;
      end
    end else begin
      if (bus.frame_tick) o_ovr <= 1'b1;
      if (m_phase == N) begin
        o_hit <= p_hit; o_idx <= p_idx; o_y <= p_y; o_cnt <= p_cnt;
      end
      m_phase <= (m_phase == N + 1) ? 0 : m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", bus.busy, (m_phase != 0) ? 1 : 0);
      check("done", bus.done, (m_phase == N + 1) ? 1 : 0);
      check("hit", bus.hit, o_hit);
      check("hit_index", bus.hit_index, o_idx);
      check("hit_y", bus.hit_y, o_y);
`ifdef PLATFORM_COLLIDER_OVERRUN_EN
      check("overrun", bus.overrun, o_ovr);
      check("hit_count", bus.hit_count, o_cnt);
`endif
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic set_plat(input int i, input int x, input int y, input bit a);
    bus.platforms[i][1] = 11'(x);
    bus.platforms[i][0] = 11'(y);
    bus.platform_activation[i] = a;
  endtask

  task automatic clear_plats();
    bus.platforms = '0;
    bus.platform_activation = '0;
  endtask

  task automatic set_doodle(input int x, input int y, input bit f);
    bus.doodle_x = 11'(x);
    bus.doodle_y = 10'(y);
    bus.falling  = f;
  endtask

  // Returns in the done cycle (#1 after its edge); lat counts cycles since the tick cycle.
  task automatic run_scan(input bit noise, output int lat, output int bc);
    @(posedge clk); #1;
    bus.frame_tick = 1'b1;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    lat = 1;
    bc  = 0;
    while (bus.done !== 1'b1 && lat < 200) begin
      if (bus.busy === 1'b1) bc++;
      if (noise) bus.frame_tick = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
      lat++;
    end
    if (bus.busy === 1'b1) bc++;
    check("scan_done_seen", bus.done, 1);
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    int lat, bc, dseen, dx, dy, px, py;
    bus.frame_tick = 1'b0;
    set_doodle(0, 0, 1'b0);
    clear_plats();
    rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hit", bus.hit, 0);
    check("rst_hit_index", bus.hit_index, 0);
    check("rst_hit_y", bus.hit_y, 0);

    // empty table
    run_scan(1'b0, lat, bc);
    check("t1_latency", lat, 94);
    check("t1_busy_cycles", bc, 94);
    check("t1_hit", bus.hit, 0);

    // single platform, feet exactly on top row
    set_plat(5, 342, 300, 1'b1);
    set_doodle(360, 221, 1'b1);
    run_scan(1'b0, lat, bc);
    check("t2_hit", bus.hit, 1);
    check("t2_hit_index", bus.hit_index, 5);
    check("t2_hit_y", bus.hit_y, 300);
    check("t2_model_hit_y", o_y, 300);
    set_doodle(360, 221, 1'b0);
    run_scan(1'b0, lat, bc);
    check("t2_rising_hit", bus.hit, 0);

    // tolerance boundary
    set_doodle(360, 231, 1'b1);
    run_scan(1'b0, lat, bc);
    check("t3_feet310_hit", bus.hit, 0);
    set_doodle(360, 230, 1'b1);
    run_scan(1'b0, lat, bc);
    check("t3_feet309_hit", bus.hit, 1);
    check("t3_feet309_index", bus.hit_index, 5);

    // priority
    clear_plats();
    set_plat(40, 342, 300, 1'b1);
    set_plat(7, 342, 300, 1'b1);
    set_doodle(360, 221, 1'b1);
    run_scan(1'b0, lat, bc);
    check("t4_hit_index", bus.hit_index, 7);
    check("t4_model_index", o_idx, 7);
`ifdef PLATFORM_COLLIDER_OVERRUN_EN
    check("t4_hit_count", bus.hit_count, 2);
`endif

    // negative coordinates
    clear_plats();
    set_plat(0, -50, -10, 1'b1);
    set_doodle(0, 0, 1'b1);
    run_scan(1'b0, lat, bc);
    check("t5_neg_hit", bus.hit, 0);
    set_plat(0, -50, 75, 1'b1);
    run_scan(1'b0, lat, bc);
    check("t5_hit", bus.hit, 1);
    check("t5_hit_y", bus.hit_y, 75);
    check("t5_hit_index", bus.hit_index, 0);

    // tick while busy, then reset mid-scan
    @(posedge clk); #1;
    bus.frame_tick = 1'b1;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    dseen = 0;
    for (int c = 2; c <= 50; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dseen++;
      bus.frame_tick = (c == 20);
`ifdef PLATFORM_COLLIDER_OVERRUN_EN
      if (c == 49) check("t6_overrun_set", bus.overrun, 1);
`endif
      if (c == 50) rst = 1'b1;
    end
    check("t6_busy_before_rst", bus.busy, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_no_done", dseen, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_done", bus.done, 0);
    check("t6_hit", bus.hit, 0);
    check("t6_hit_index", bus.hit_index, 0);
    check("t6_hit_y", bus.hit_y, 0);
`ifdef PLATFORM_COLLIDER_OVERRUN_EN
    check("t6_overrun_clr", bus.overrun, 0);
`endif

    // randomized frames
    for (int s = 0; s < 40; s++) begin
      dx = (s % 5 == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 900));
      dy = int'($urandom_range(0, 600));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 4) == 0) px = int'($urandom_range(0, 2047)) - 1024;
        else px = dx + int'($urandom_range(0, 260)) - 160;
        if ($urandom_range(0, 4) == 0) py = int'($urandom_range(0, 2047)) - 1024;
        else py = dy + DH - 1 + int'($urandom_range(0, 30)) - 15;
        if (px > 1023) px = 1023;
        if (py > 1023) py = 1023;
        set_plat(i, px, py, ($urandom_range(0, 2) == 0));
      end
      set_doodle(dx, dy, ($urandom_range(0, 3) != 0));
      run_scan(($urandom_range(0, 2) == 0), lat, bc);
      check("rnd_latency", lat, 94);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
